// File: rtl/icache_direct_pkg.sv
// icache_direct_pkg
// Shared constants and types for the direct-mapped instruction cache.
//   `AddressWidth / `IDWidth : address and instruction widths (32 bits)
//   cache_state_e            : controller states (IDLE, MISS, DISCARD)
//   tag_width()              : tag width for a given index width
// The optional statistics counters in icache_direct are enabled by
// defining the macro ICACHE_STATS_EN.

`ifndef ICACHE_DIRECT_DEFS
`define ICACHE_DIRECT_DEFS
`define AddressWidth 32
`define IDWidth 32
`endif

package icache_direct_pkg;

  localparam int DEFAULT_INDEX_BITS = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MISS    = 2'b01,
    DISCARD = 2'b10
  } cache_state_e;

  // Tag is everything above the index and the two byte-offset bits.
  function automatic int tag_width(input int index_bits);
    return `AddressWidth - index_bits - 2;
  endfunction

endpackage

// File: rtl/icache_direct_array.sv
// icache_array
// Valid/tag/data storage for the direct-mapped instruction cache.
// Ports:
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_rd_index                : asynchronous read index
//   o_rd_valid/o_rd_tag/o_rd_data : contents of the addressed line
//   i_wr_en/i_wr_index/i_wr_tag/i_wr_data : single synchronous write port
// Only the valid bits are reset; tag and data are don't-care while invalid.

module icache_array
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [INDEX_BITS-1:0]              i_rd_index,
  output logic                               o_rd_valid,
  output logic [tag_width(INDEX_BITS)-1:0]   o_rd_tag,
  output logic [`IDWidth-1:0]                o_rd_data,
  input  logic                               i_wr_en,
  input  logic [INDEX_BITS-1:0]              i_wr_index,
  input  logic [tag_width(INDEX_BITS)-1:0]   i_wr_tag,
  input  logic [`IDWidth-1:0]                i_wr_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = tag_width(INDEX_BITS);

  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [`IDWidth-1:0] r_data [LINES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/icache_direct.sv
// icache_direct
// Direct-mapped instruction cache, one 32-bit instruction per line.
// Hits answer one cycle after the request; a miss holds a single request
// on the RAM controller instruction port, fills the line and answers.
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global enable/freeze)
//   flush_in                           : abandon the current request
//   fetch_en_in/fetch_addr_in          : fetch request (level)
//   fetch_rdy_out/fetch_inst_out       : one-cycle answer pulse + word
//   mem_en_out/mem_addr_out            : request to RAM controller
//   mem_rdy_in/mem_inst_in             : controller done pulse + word
//   hit_cnt_out/miss_cnt_out           : only when ICACHE_STATS_EN is defined

module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     fetch_en_in,
  input  logic [`AddressWidth-1:0] fetch_addr_in,
  output logic                     fetch_rdy_out,
  output logic [`IDWidth-1:0]      fetch_inst_out,
  output logic                     mem_en_out,
  output logic [`AddressWidth-1:0] mem_addr_out,
  input  logic                     mem_rdy_in,
  input  logic [`IDWidth-1:0]      mem_inst_in
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]              hit_cnt_out,
  output logic [31:0]              miss_cnt_out
`endif
);

  localparam int TAG_W = tag_width(INDEX_BITS);

  cache_state_e             r_state, w_state_nxt;
  logic                     r_fetch_rdy, w_fetch_rdy_nxt;
  logic [`IDWidth-1:0]      r_fetch_inst, w_fetch_inst_nxt;
  logic                     r_mem_en, w_mem_en_nxt;
  logic [`AddressWidth-1:0] r_mem_addr, w_mem_addr_nxt;

  logic [INDEX_BITS-1:0]    w_fetch_index, w_fill_index;
  logic [TAG_W-1:0]         w_fetch_tag, w_fill_tag, w_rd_tag;
  logic                     w_rd_valid;
  logic [`IDWidth-1:0]      w_rd_data;
  logic                     w_req, w_hit, w_fill, w_wr_en;
  logic                     w_unused_addr_lsb;

  assign w_fetch_index     = fetch_addr_in[INDEX_BITS+1:2];
  assign w_fetch_tag       = fetch_addr_in[`AddressWidth-1:INDEX_BITS+2];
  // The line being filled is always the one held on mem_addr_out.
  assign w_fill_index      = r_mem_addr[INDEX_BITS+1:2];
  assign w_fill_tag        = r_mem_addr[`AddressWidth-1:INDEX_BITS+2];
  assign w_unused_addr_lsb = ^fetch_addr_in[1:0];

  // A flush overrides a fetch request presented in the same cycle.
  assign w_req   = fetch_en_in && !flush_in;
  assign w_hit   = w_rd_valid && (w_rd_tag == w_fetch_tag);
  assign w_wr_en = w_fill && rdy_in;

  icache_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .i_clk     (clk_in),
    .i_rst_n   (rst_in),
    .i_rd_index(w_fetch_index),
    .o_rd_valid(w_rd_valid),
    .o_rd_tag  (w_rd_tag),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_index(w_fill_index),
    .i_wr_tag  (w_fill_tag),
    .i_wr_data (mem_inst_in)
  );

  // State and all outputs are registered; rdy_in low freezes everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= IDLE;
      r_fetch_rdy  <= 1'b0;
      r_fetch_inst <= '0;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
    end else if (rdy_in) begin
      r_state      <= w_state_nxt;
      r_fetch_rdy  <= w_fetch_rdy_nxt;
      r_fetch_inst <= w_fetch_inst_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
    end
  end

  // A flush during a miss cannot cancel the memory access, so it only
  // diverts to DISCARD where the fill completes silently.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req && !w_hit) w_state_nxt = MISS;
      MISS: begin
        if (mem_rdy_in)    w_state_nxt = IDLE;
        else if (flush_in) w_state_nxt = DISCARD;
      end
      DISCARD: if (mem_rdy_in) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // mem_en_out drops on the fill edge so the controller never sees a
  // second request for the same access; the answer is suppressed when a
  // flush arrived before or together with mem_rdy_in.
  always_comb begin
    w_fetch_rdy_nxt  = 1'b0;
    w_fetch_inst_nxt = r_fetch_inst;
    w_mem_en_nxt     = r_mem_en;
    w_mem_addr_nxt   = r_mem_addr;
    w_fill           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_fetch_rdy_nxt  = 1'b1;
            w_fetch_inst_nxt = w_rd_data;
          end else begin
            w_mem_en_nxt   = 1'b1;
            w_mem_addr_nxt = {fetch_addr_in[`AddressWidth-1:2], 2'b00};
          end
        end
      end
      MISS: begin
        if (mem_rdy_in) begin
          w_fill       = 1'b1;
          w_mem_en_nxt = 1'b0;
          if (!flush_in) begin
            w_fetch_rdy_nxt  = 1'b1;
            w_fetch_inst_nxt = mem_inst_in;
          end
        end
      end
      DISCARD: begin
        if (mem_rdy_in) begin
          w_fill       = 1'b1;
          w_mem_en_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign fetch_rdy_out  = r_fetch_rdy;
  assign fetch_inst_out = r_fetch_inst;
  assign mem_en_out     = r_mem_en;
  assign mem_addr_out   = r_mem_addr;

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (rdy_in && (r_state == IDLE) && w_req) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_out  = r_hit_cnt;
  assign miss_cnt_out = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct
// Directed bench for icache_direct with a transaction-level cache model
// (line address + data per slot) and a simple RAM controller responder.
// Optional counters are checked when ICACHE_STATS_EN is defined.

module tb_icache_direct;

  localparam int LINES = 128;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        fetch_en_in;
  logic [31:0] fetch_addr_in;
  logic        fetch_rdy_out;
  logic [31:0] fetch_inst_out;
  logic        mem_en_out;
  logic [31:0] mem_addr_out;
  logic        mem_rdy_in;
  logic [31:0] mem_inst_in;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_out;
  logic [31:0] miss_cnt_out;
`endif

  int checks = 0;
  int errors = 0;
  bit cmpOn  = 1'b0;
  int memLatency = 5;
  int waitCnt = 0;

  logic [31:0] lineAddr [int];
  logic [31:0] lineData [int];
  bit          mPending, mDiscard;
  logic [31:0] mAddr;
  logic        expRdy, expMemEn;
  logic [31:0] expInst, expMemAddr;
  int          mHits, mMisses;

  icache_direct dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush_in      (flush_in),
    .fetch_en_in   (fetch_en_in),
    .fetch_addr_in (fetch_addr_in),
    .fetch_rdy_out (fetch_rdy_out),
    .fetch_inst_out(fetch_inst_out),
    .mem_en_out    (mem_en_out),
    .mem_addr_out  (mem_addr_out),
    .mem_rdy_in    (mem_rdy_in),
    .mem_inst_in   (mem_inst_in)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_out   (hit_cnt_out),
    .miss_cnt_out  (miss_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Backing memory contents seen through the controller.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0010_0093;
    return (a ^ 32'h5A5A_0000) + 32'd7;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Present one fetch and wait (bounded) for its answer pulse.
  task automatic applyStimulus(input logic [31:0] addr, output int cycles,
                               output logic [31:0] data, output bit sawEn);
    cycles = 0;
    data   = '0;
    sawEn  = 1'b0;
    fetch_en_in   = 1'b1;
    fetch_addr_in = addr;
    while (1) begin
      @(negedge clk_in);
      cycles++;
      if (mem_en_out) sawEn = 1'b1;
      if (fetch_rdy_out) begin
        data = fetch_inst_out;
        break;
      end
      if (cycles >= 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL fetch_timeout addr=%h: no fetch_rdy_out in 50 cycles", addr);
        break;
      end
    end
    fetch_en_in = 1'b0;
  endtask

  task automatic runFetch(input string name, input logic [31:0] addr, input int expCycles,
                          input logic [31:0] expData, input bit expEn);
    int          cyc;
    logic [31:0] data;
    bit          sawEn;
    applyStimulus(addr, cyc, data, sawEn);
    checkOutput({name, "_latency"}, cyc, expCycles);
    checkOutput({name, "_data"}, data, expData);
    checkOutput({name, "_data_vs_mem"}, data, memWord(addr & ~32'd3));
    checkOutput({name, "_mem_req"}, {31'd0, sawEn}, {31'd0, expEn});
  endtask

  // RAM controller: answers a held request after memLatency cycles.
  initial begin
    mem_rdy_in  = 1'b0;
    mem_inst_in = '0;
    forever begin
      @(negedge clk_in);
      mem_rdy_in = 1'b0;
      if (rst_in && rdy_in && mem_en_out) begin
        waitCnt++;
        if (waitCnt >= memLatency) begin
          mem_rdy_in  = 1'b1;
          mem_inst_in = memWord(mem_addr_out);
          waitCnt     = 0;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Transaction-level cache model: one outstanding miss at most, lines
  // remembered by their full word address.
  always @(posedge clk_in or negedge rst_in) begin
    int          slot;
    logic [31:0] a;
    if (!rst_in) begin
      lineAddr.delete();
      lineData.delete();
      mPending = 0; mDiscard = 0; mAddr = '0;
      expRdy = 1'b0; expInst = '0; expMemEn = 1'b0; expMemAddr = '0;
      mHits = 0; mMisses = 0;
    end else if (rdy_in) begin
      if (mPending) begin
        expRdy = 1'b0;
        if (mem_rdy_in) begin
          slot = int'((mAddr >> 2) % LINES);
          lineAddr[slot] = mAddr;
          lineData[slot] = mem_inst_in;
          mPending = 0;
          expMemEn = 1'b0;
          if (!mDiscard && !flush_in) begin
            expRdy  = 1'b1;
            expInst = mem_inst_in;
          end
          mDiscard = 0;
        end else if (flush_in) begin
          mDiscard = 1;
        end
      end else if (fetch_en_in && !flush_in) begin
        a = fetch_addr_in & ~32'd3;
        slot = int'((a >> 2) % LINES);
        if (lineAddr.exists(slot) && lineAddr[slot] == a) begin
          expRdy  = 1'b1;
          expInst = lineData[slot];
          mHits++;
        end else begin
          expRdy     = 1'b0;
          mPending   = 1;
          mAddr      = a;
          expMemEn   = 1'b1;
          expMemAddr = a;
          mMisses++;
        end
      end else begin
        expRdy = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk_in) begin
    if (cmpOn) begin
      checkOutput("cmp_fetch_rdy", {31'd0, fetch_rdy_out}, {31'd0, expRdy});
      if (expRdy) checkOutput("cmp_fetch_inst", fetch_inst_out, expInst);
      checkOutput("cmp_mem_en", {31'd0, mem_en_out}, {31'd0, expMemEn});
      if (expMemEn) checkOutput("cmp_mem_addr", mem_addr_out, expMemAddr);
`ifdef ICACHE_STATS_EN
      checkOutput("cmp_hit_cnt", hit_cnt_out, mHits);
      checkOutput("cmp_miss_cnt", miss_cnt_out, mMisses);
`endif
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int enCycles;
    int rdyPulses;
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    fetch_en_in = 1'b0; fetch_addr_in = '0;
    #1;
    checkOutput("reset_fetch_rdy", {31'd0, fetch_rdy_out}, 32'd0);
    checkOutput("reset_fetch_inst", fetch_inst_out, 32'd0);
    checkOutput("reset_mem_en", {31'd0, mem_en_out}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr_out, 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    cmpOn  = 1'b1;

    $display("[TB] cold miss, hit, back-to-back hits, ignored low bits");
    runFetch("cold_miss", 32'h0000_0100, 6, 32'h0010_0093, 1'b1);
    checkOutput("cold_miss_en_dropped", {31'd0, mem_en_out}, 32'd0);
    runFetch("hit_after_fill", 32'h0000_0100, 1, 32'h0010_0093, 1'b0);
    runFetch("fill_104", 32'h0000_0104, 6, 32'h5A5A_010B, 1'b1);
    runFetch("b2b_hit_100", 32'h0000_0100, 1, 32'h0010_0093, 1'b0);
    runFetch("b2b_hit_104", 32'h0000_0104, 1, 32'h5A5A_010B, 1'b0);
    runFetch("lsb_ignored", 32'h0000_0106, 1, 32'h5A5A_010B, 1'b0);

    $display("[TB] conflict eviction");
    runFetch("evict_300", 32'h0000_0300, 6, 32'h5A5A_0307, 1'b1);
    runFetch("refetch_100", 32'h0000_0100, 6, 32'h0010_0093, 1'b1);

    $display("[TB] flush during miss");
    fetch_en_in = 1'b1; fetch_addr_in = 32'h0000_0200;
    @(negedge clk_in);
    fetch_en_in = 1'b0;
    @(negedge clk_in);
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    enCycles = 3; rdyPulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (fetch_rdy_out) rdyPulses++;
      if (!mem_en_out) break;
      @(negedge clk_in);
      if (mem_en_out) enCycles++;
    end
    if (fetch_rdy_out) rdyPulses++;
    checkOutput("flush_en_held", enCycles, 5);
    checkOutput("flush_no_rdy", rdyPulses, 0);
    checkOutput("flush_en_dropped", {31'd0, mem_en_out}, 32'd0);
    runFetch("after_flush_hit", 32'h0000_0200, 1, 32'h5A5A_0207, 1'b0);

    $display("[TB] flush together with mem_rdy_in");
    fetch_en_in = 1'b1; fetch_addr_in = 32'h0000_0500;
    @(negedge clk_in);
    fetch_en_in = 1'b0;
    repeat (4) @(negedge clk_in);
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    checkOutput("flush_fill_no_rdy", {31'd0, fetch_rdy_out}, 32'd0);
    checkOutput("flush_fill_en_low", {31'd0, mem_en_out}, 32'd0);
    runFetch("flush_fill_hit", 32'h0000_0500, 1, 32'h5A5A_0507, 1'b0);

    $display("[TB] asynchronous reset during a miss");
    fetch_en_in = 1'b1; fetch_addr_in = 32'h0000_0400;
    @(negedge clk_in);
    @(negedge clk_in);
    checkOutput("pre_reset_mem_en", {31'd0, mem_en_out}, 32'd1);
    #2;
    rst_in = 1'b0; fetch_en_in = 1'b0;
    #1;
    checkOutput("async_reset_mem_en", {31'd0, mem_en_out}, 32'd0);
    checkOutput("async_reset_mem_addr", mem_addr_out, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    runFetch("post_reset_miss", 32'h0000_0200, 6, 32'h5A5A_0207, 1'b1);

    $display("[TB] rdy_in low for three cycles during a hit");
    fetch_en_in = 1'b1; fetch_addr_in = 32'h0000_0200;
    @(negedge clk_in);
    checkOutput("freeze_hit_rdy", {31'd0, fetch_rdy_out}, 32'd1);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      checkOutput("freeze_rdy_held", {31'd0, fetch_rdy_out}, 32'd1);
      checkOutput("freeze_inst_held", fetch_inst_out, 32'h5A5A_0207);
    end
    rdy_in = 1'b1; fetch_en_in = 1'b0;
    @(negedge clk_in);
    checkOutput("resume_rdy_low", {31'd0, fetch_rdy_out}, 32'd0);
    runFetch("resume_miss", 32'h0000_0100, 6, 32'h0010_0093, 1'b1);
    runFetch("resume_hit", 32'h0000_0200, 1, 32'h5A5A_0207, 1'b0);

    @(negedge clk_in);
    cmpOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache, one 32-bit instruction per line.
- Sits between the instruction fetcher (upstream) and the byte-serial RAM controller (downstream).
- Serves fetch hits with one-cycle latency.
- On a miss, issues a single held request on the controller's instruction port (en/addr in, rdy/inst out). It then fills the line and answers the fetcher.

Parameters:
- INDEX_BITS, 7, log2 of line count (128 lines); tag = addr[31 : INDEX_BITS+2], index = addr[INDEX_BITS+1 : 2].

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global enable; low freezes all state and outputs
- flush_in  input  1  fetch redirect; abandon current request
- fetch_en_in  input  1  fetch request valid, level
- fetch_addr_in  input  `AddressWidth  fetch PC, word aligned
- fetch_rdy_out  output  1  one-cycle pulse, fetch_inst_out valid
- fetch_inst_out  output  `IDWidth  instruction
- mem_en_out  output  1  request to RAM controller instruction port
- mem_addr_out  output  `AddressWidth  miss address, word aligned
- mem_rdy_in  input  1  controller done pulse
- mem_inst_in  input  `IDWidth  fetched word

Behaviour:
- Reset (rst_in=0, async), all registered:
  - every valid bit = 0
  - state = IDLE
  - fetch_rdy_out = 0, fetch_inst_out = 0
  - mem_en_out = 0, mem_addr_out = 0
- States and transitions:
  - IDLE, sampling each rdy_in=1 edge:
    - No request, or flush_in=1: stay IDLE, fetch_rdy_out <= 0.
    - Hit (valid && tag match): fetch_inst_out <= line data; fetch_rdy_out <= 1 next cycle; stay IDLE.
    - Miss: mem_en_out <= 1, mem_addr_out <= {fetch_addr_in[31:2], 2'b00}; go to MISS.
    - Throughput is one hit per cycle. A request sampled in the same cycle fetch_rdy_out is high is legal.
  - MISS:
    - mem_en_out and mem_addr_out held constant until mem_rdy_in=1.
    - On the mem_rdy_in edge:
      - write line (valid=1, tag, data=mem_inst_in)
      - mem_en_out <= 0
      - fetch_inst_out <= mem_inst_in, fetch_rdy_out <= 1
      - go to IDLE
    - mem_en_out must be low on the edge after mem_rdy_in, so the controller does not restart the same access.
    - Miss latency = controller latency + 1 cycle.
  - DISCARD, entered from MISS when flush_in=1 before mem_rdy_in:
    - The memory access cannot be aborted; mem_en_out stays held.
    - On mem_rdy_in: line still filled (data correct for that address), fetch_rdy_out stays 0, go to IDLE.
- Simultaneous events:
  - flush_in with mem_rdy_in in MISS: fill the line, suppress fetch_rdy_out, go to IDLE.
  - flush_in in IDLE overrides the fetch request.
  - fetch_rdy_out is never asserted for a request made before flush_in.
- fetch_en_in in MISS/DISCARD is ignored; the requester holds it until fetch_rdy_out.
- rdy_in=0: no state, array or output changes; mem_rdy_in is assumed not pulsed by the controller while rdy_in=0 (same global rdy).
- Reset mid-miss: all valids cleared, mem_en_out drops immediately. The controller is reset by the same reset.
- Address bits [1:0] are ignored.
- Only a fill writes the array.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined, adds ports:
  - hit_cnt_out  output  32  count of IDLE hits answered
  - miss_cnt_out  output  32  count of misses entering MISS
- Both counters reset to 0, wrap at 2^32, and freeze when rdy_in=0.
- Flushed misses still count as misses.
- Undefined: no ports, no counters, identical behaviour otherwise.

Decomposition:
- Shared constant header holds `AddressWidth, `IDWidth and the cache state encodings (IDLE=2'b00, MISS=2'b01, DISCARD=2'b10).
- One sub-module, icache_array:
  - valid/tag/data storage
  - asynchronous read by index
  - single synchronous write port
  - async-reset valid clear
- The FSM and handshakes stay in icache_direct.

Test Plan:
- Cold miss: fetch 0x0000_0100, memory word 0x0010_0093; controller rdy after 5 cycles:
  - mem_en_out high with mem_addr_out=0x100 until rdy.
  - fetch_rdy_out pulses 1 cycle later with 0x0010_0093.
  - mem_en_out low at the next edge.
- Hit after fill: refetch 0x100 → fetch_rdy_out next cycle, data 0x0010_0093, mem_en_out stays 0.
- Back-to-back hits 0x100, 0x104 (both filled) → two consecutive fetch_rdy_out pulses with correct data.
- Conflict eviction (INDEX_BITS=7): fetch 0x100 then 0x300 (same index, different tag):
  - second access misses and replaces the line.
  - refetching 0x100 misses again.
- Flush mid-miss: flush_in at cycle 2 of a miss to 0x200:
  - mem_en_out held until mem_rdy_in.
  - no fetch_rdy_out.
  - a later fetch of 0x200 hits.
- Async reset mid-miss, plus rdy_in low for 3 cycles during a hit:
  - Reset: mem_en_out drops without a clock edge; the next fetch misses.
  - rdy_in low: fetch_rdy_out and state frozen, then resume.
